// File: rtl/stack_sequencer_pkg.sv
// Shared types and default geometry for the MCU stack sequencer.
// The stack grows downward from STACK_BASE toward STACK_LIMIT.
package stack_sequencer_pkg;

  localparam int unsigned AW_DEF = 8;
  localparam int unsigned DW_DEF = 10;
  localparam logic [7:0]  STACK_BASE_DEF  = 8'h00;
  localparam logic [7:0]  STACK_LIMIT_DEF = 8'hC0;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_INT  = 3'd5,
    OP_RETI = 3'd6,
    OP_LDSP = 3'd7
  } stack_op_t;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_WR1   = 4'd1,
    ST_WR2   = 4'd2,
    ST_RD1   = 4'd3,
    ST_RD2   = 4'd4,
    ST_CAP   = 4'd5,
    ST_LD    = 4'd6,
    ST_NOP1  = 4'd7,
    ST_ABORT = 4'd8
  } stack_state_t;

endpackage

// File: rtl/stack_ptr_reg.sv
// Stack pointer register: load has priority over increment, increment over decrement.
// Arithmetic wraps modulo 2^AW.
module stack_ptr_reg #(
  parameter int unsigned   AW      = 8,
  parameter logic [AW-1:0] RST_VAL = '0
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          ld_i,
  input  logic [AW-1:0] ld_data_i,
  input  logic          incr_i,
  input  logic          decr_i,
  output logic [AW-1:0] sp_o
);

  localparam logic [AW-1:0] ONE = AW'(1);

  logic [AW-1:0] sp_q, sp_d;

  always_comb begin
    sp_d = sp_q;
    if (ld_i)        sp_d = ld_data_i;
    else if (incr_i) sp_d = sp_q + ONE;
    else if (decr_i) sp_d = sp_q - ONE;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sp_q <= RST_VAL;
    else          sp_q <= sp_d;
  end

  assign sp_o = sp_q;

endmodule

// File: rtl/stack_sequencer.sv
// Stack traffic sequencer: owns SP, drives the scratch RAM for push/pop/call/ret/int/reti,
// and aborts ops that would overflow or underflow the stack.
//
// state | meaning
// IDLE  | waiting for an op, op_ready_o high
// WR1   | write data/PC at SP-1, SP decrements
// WR2   | INT only: write {0,C,Z} at SP-1, SP decrements
// RD1   | read address SP, SP increments
// RD2   | RETI only: capture flags, read PC at SP, SP increments
// CAP   | present/capture popped word
// LD    | load SP, clear sticky OVF/UNF
// NOP1  | single-cycle no-op
// ABORT | limit check failed: DONE+ERR, nothing else changes
module stack_sequencer
  import stack_sequencer_pkg::*;
#(
  parameter int unsigned   AW          = AW_DEF,
  parameter int unsigned   DW          = DW_DEF,
  parameter logic [AW-1:0] STACK_BASE  = AW'(STACK_BASE_DEF),
  parameter logic [AW-1:0] STACK_LIMIT = AW'(STACK_LIMIT_DEF)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          op_valid_i,
  input  logic [2:0]    op_i,
  output logic          op_ready_o,
  input  logic [DW-1:0] wdata_i,
  input  logic [1:0]    flags_i,
  input  logic [AW-1:0] sp_ld_data_i,
  output logic          done_o,
  output logic          err_o,
  output logic [DW-1:0] rdata_o,
  output logic [1:0]    rflags_o,
  output logic [AW-1:0] scr_addr_o,
  output logic [DW-1:0] scr_wdata_o,
  output logic          scr_we_o,
  input  logic [DW-1:0] scr_rdata_i,
  output logic [AW-1:0] sp_o,
  output logic          ovf_o,
  output logic          unf_o
);

  localparam logic [AW-1:0] ONE     = AW'(1);
  localparam logic [AW-1:0] TWO     = AW'(2);
  localparam logic [AW-1:0] CAP     = STACK_BASE - STACK_LIMIT;
  localparam logic [AW-1:0] CAP_INT = CAP - TWO;

  stack_state_t  state_q, state_d;
  stack_op_t     op_q, op_d, op_in;
  logic [DW-1:0] data_q, data_d;
  logic [1:0]    flags_q, flags_d;
  logic [AW-1:0] ld_q, ld_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rflags_q, rflags_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;

  logic [AW-1:0] sp, sp_m1, depth;
  logic          sp_ld, sp_incr, sp_decr;

  assign op_in = stack_op_t'(op_i);
  assign sp_m1 = sp - ONE;
  assign depth = STACK_BASE - sp;

  stack_ptr_reg #(
    .AW      (AW),
    .RST_VAL (STACK_BASE)
  ) u_sp (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .ld_i      (sp_ld),
    .ld_data_i (ld_q),
    .incr_i    (sp_incr),
    .decr_i    (sp_decr),
    .sp_o      (sp)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    flags_d     = flags_q;
    ld_d        = ld_q;
    rdata_d     = rdata_q;
    rflags_d    = rflags_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    sp_ld       = 1'b0;
    sp_incr     = 1'b0;
    sp_decr     = 1'b0;
    op_ready_o  = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    scr_we_o    = 1'b0;
    scr_addr_o  = sp;
    scr_wdata_o = data_q;

    case (state_q)
      ST_IDLE: begin
        op_ready_o = 1'b1;
        if (op_valid_i) begin
          op_d    = op_in;
          data_d  = wdata_i;
          flags_d = flags_i;
          ld_d    = sp_ld_data_i;
          // Limits are checked once here so an op either runs fully or not at all.
          case (op_in)
            OP_PUSH, OP_CALL: begin
              if (depth < CAP) state_d = ST_WR1;
              else begin
                state_d = ST_ABORT;
                ovf_d   = 1'b1;
              end
            end
            OP_INT: begin
              if (depth <= CAP_INT) state_d = ST_WR1;
              else begin
                state_d = ST_ABORT;
                ovf_d   = 1'b1;
              end
            end
            OP_POP, OP_RET: begin
              if (depth >= ONE) state_d = ST_RD1;
              else begin
                state_d = ST_ABORT;
                unf_d   = 1'b1;
              end
            end
            OP_RETI: begin
              if (depth >= TWO) state_d = ST_RD1;
              else begin
                state_d = ST_ABORT;
                unf_d   = 1'b1;
              end
            end
            OP_LDSP: state_d = ST_LD;
            default: state_d = ST_NOP1;
          endcase
        end
      end
      ST_WR1: begin
        scr_we_o    = 1'b1;
        scr_addr_o  = sp_m1;
        scr_wdata_o = data_q;
        sp_decr     = 1'b1;
        if (op_q == OP_INT) state_d = ST_WR2;
        else begin
          done_o  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WR2: begin
        scr_we_o    = 1'b1;
        scr_addr_o  = sp_m1;
        scr_wdata_o = {{(DW-2){1'b0}}, flags_q};
        sp_decr     = 1'b1;
        done_o      = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_RD1: begin
        sp_incr = 1'b1;
        state_d = (op_q == OP_RETI) ? ST_RD2 : ST_CAP;
      end
      ST_RD2: begin
        // Flags word was addressed in RD1 and arrives now; the PC word is addressed here.
        sp_incr  = 1'b1;
        rflags_d = scr_rdata_i[1:0];
        state_d  = ST_CAP;
      end
      ST_CAP: begin
        rdata_d = scr_rdata_i;
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_LD: begin
        sp_ld   = 1'b1;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_NOP1: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ABORT: begin
        done_o  = 1'b1;
        err_o   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NOP;
      data_q   <= '0;
      flags_q  <= '0;
      ld_q     <= '0;
      rdata_q  <= '0;
      rflags_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      flags_q  <= flags_d;
      ld_q     <= ld_d;
      rdata_q  <= rdata_d;
      rflags_q <= rflags_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // The popped word is forwarded straight from the RAM during CAP so it is valid with DONE.
  assign rdata_o  = (state_q == ST_CAP) ? scr_rdata_i : rdata_q;
  assign rflags_o = rflags_q;
  assign sp_o     = sp;
  assign ovf_o    = ovf_q;
  assign unf_o    = unf_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer: directed scenarios plus randomized ops
// compared against an address-level stack model and a bench-side scratch RAM.
module tb_stack_sequencer;
  import stack_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       op_valid;
  logic [2:0] op;
  logic       op_ready;
  logic [9:0] wd;
  logic [1:0] fl;
  logic [7:0] ld;
  logic       done, err;
  logic [9:0] rdata;
  logic [1:0] rflags;
  logic [7:0] scr_addr;
  logic [9:0] scr_wdata;
  logic       scr_we;
  logic [9:0] scr_rdata;
  logic [7:0] sp_out;
  logic       ovf, unf;

  always #5 clk = ~clk;

  stack_sequencer dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .op_valid_i   (op_valid),
    .op_i         (op),
    .op_ready_o   (op_ready),
    .wdata_i      (wd),
    .flags_i      (fl),
    .sp_ld_data_i (ld),
    .done_o       (done),
    .err_o        (err),
    .rdata_o      (rdata),
    .rflags_o     (rflags),
    .scr_addr_o   (scr_addr),
    .scr_wdata_o  (scr_wdata),
    .scr_we_o     (scr_we),
    .scr_rdata_i  (scr_rdata),
    .sp_o         (sp_out),
    .ovf_o        (ovf),
    .unf_o        (unf)
  );

  // Bench-side scratch RAM with synchronous read
  logic [9:0] ram [0:255];
  logic [9:0] model_mem [0:255];
  logic       load_ram;

  always @(posedge clk) begin
    if (load_ram) begin
      for (int i = 0; i < 256; i++) ram[i] <= model_mem[i];
    end else if (scr_we) begin
      ram[scr_addr] <= scr_wdata;
    end
    scr_rdata <= ram[scr_addr];
  end

  // Reference model state
  logic [7:0] sp_m;
  logic       ovf_m, unf_m;
  logic [9:0] rd_m;
  logic [1:0] rf_m;

  int n_chk, n_pass;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_state(input string tag);
    int bad;
    n_chk++; if (sp_out !== sp_m) $display("FAIL %s sp got=%h exp=%h", tag, sp_out, sp_m); else n_pass++;
    n_chk++; if (ovf !== ovf_m) $display("FAIL %s ovf got=%b exp=%b", tag, ovf, ovf_m); else n_pass++;
    n_chk++; if (unf !== unf_m) $display("FAIL %s unf got=%b exp=%b", tag, unf, unf_m); else n_pass++;
    n_chk++; if (rdata !== rd_m) $display("FAIL %s rdata got=%h exp=%h", tag, rdata, rd_m); else n_pass++;
    n_chk++; if (rflags !== rf_m) $display("FAIL %s rflags got=%b exp=%b", tag, rflags, rf_m); else n_pass++;
    n_chk++; if (op_ready !== 1'b1) $display("FAIL %s op_ready got=%b exp=1", tag, op_ready); else n_pass++;
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== model_mem[i]) bad++;
    n_chk++; if (bad != 0) $display("FAIL %s ram contents: %0d words differ, exp 0", tag, bad); else n_pass++;
  endtask

  // Issue one op from IDLE, follow it to DONE, and compare against the model.
  task automatic run_op(input logic [2:0] o, input logic [9:0] w, input logic [1:0] f,
                        input logic [7:0] l, input string tag);
    logic [7:0] depth;
    logic [7:0] ew_addr [2];
    logic [9:0] ew_data [2];
    int exp_lat, exp_we, lat, we_seen, busy_ready;
    logic exp_err, got_err, is_pop, is_reti;
    depth = 8'h00 - sp_m;
    exp_lat = 1; exp_we = 0; exp_err = 1'b0; is_pop = 1'b0; is_reti = 1'b0;
    ew_addr[0] = '0; ew_addr[1] = '0; ew_data[0] = '0; ew_data[1] = '0;
    case (o)
      OP_PUSH, OP_CALL: begin
        if (depth < 8'd64) begin
          ew_addr[0] = sp_m - 8'd1; ew_data[0] = w;
          model_mem[ew_addr[0]] = w; sp_m = sp_m - 8'd1; exp_we = 1;
        end else begin exp_err = 1'b1; ovf_m = 1'b1; end
      end
      OP_INT: begin
        if (depth <= 8'd62) begin
          ew_addr[0] = sp_m - 8'd1; ew_data[0] = w;
          ew_addr[1] = sp_m - 8'd2; ew_data[1] = {8'b0, f};
          model_mem[ew_addr[0]] = w; model_mem[ew_addr[1]] = {8'b0, f};
          sp_m = sp_m - 8'd2; exp_we = 2; exp_lat = 2;
        end else begin exp_err = 1'b1; ovf_m = 1'b1; end
      end
      OP_POP, OP_RET: begin
        if (depth >= 8'd1) begin
          rd_m = model_mem[sp_m]; sp_m = sp_m + 8'd1; exp_lat = 2; is_pop = 1'b1;
        end else begin exp_err = 1'b1; unf_m = 1'b1; end
      end
      OP_RETI: begin
        if (depth >= 8'd2) begin
          rf_m = model_mem[sp_m][1:0];
          sp_m = sp_m + 8'd1;
          rd_m = model_mem[sp_m];
          sp_m = sp_m + 8'd1;
          exp_lat = 3; is_pop = 1'b1; is_reti = 1'b1;
        end else begin exp_err = 1'b1; unf_m = 1'b1; end
      end
      OP_LDSP: begin sp_m = l; ovf_m = 1'b0; unf_m = 1'b0; end
      default: ;
    endcase

    @(negedge clk);
    op_valid = 1'b1; op = o; wd = w; fl = f; ld = l;
    @(posedge clk);
    lat = 0; we_seen = 0; busy_ready = 0; got_err = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) op_valid = 1'b0;
      if (op_ready) busy_ready++;
      if (scr_we) begin
        n_chk++;
        if (we_seen < 2 && scr_addr === ew_addr[we_seen] && scr_wdata === ew_data[we_seen]) n_pass++;
        else $display("FAIL %s write%0d got addr=%h data=%h exp addr=%h data=%h",
                      tag, we_seen, scr_addr, scr_wdata, ew_addr[we_seen % 2], ew_data[we_seen % 2]);
        we_seen++;
      end
      if (done) begin
        lat = c; got_err = err;
        if (is_pop) begin
          n_chk++; if (rdata !== rd_m) $display("FAIL %s rdata@done got=%h exp=%h", tag, rdata, rd_m); else n_pass++;
        end
        if (is_reti) begin
          n_chk++; if (rflags !== rf_m) $display("FAIL %s rflags@done got=%b exp=%b", tag, rflags, rf_m); else n_pass++;
        end
        break;
      end
    end
    n_chk++; if (lat != exp_lat) $display("FAIL %s latency got=%0d exp=%0d", tag, lat, exp_lat); else n_pass++;
    n_chk++; if (got_err !== exp_err) $display("FAIL %s err got=%b exp=%b", tag, got_err, exp_err); else n_pass++;
    n_chk++; if (we_seen != exp_we) $display("FAIL %s write count got=%0d exp=%0d", tag, we_seen, exp_we); else n_pass++;
    n_chk++; if (busy_ready != 0) $display("FAIL %s op_ready while busy got=%0d cycles exp=0", tag, busy_ready); else n_pass++;
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_ram = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (scr_we !== 1'b0) $display("FAIL reset we got=%b exp=0", scr_we); else n_pass++;
    n_chk++; if (done !== 1'b0 || err !== 1'b0) $display("FAIL reset done/err got=%b/%b exp=0/0", done, err); else n_pass++;
    n_chk++; if (scr_addr !== 8'h00) $display("FAIL reset scr_addr got=%h exp=00", scr_addr); else n_pass++;
    load_ram = 1'b0;
    rst_n = 1'b1;
    sp_m = 8'h00; ovf_m = 1'b0; unf_m = 1'b0; rd_m = '0; rf_m = '0;
    @(negedge clk);
    check_state("reset");
  endtask

  task automatic test_push_pop();
    run_op(OP_PUSH, 10'h2A5, 2'b00, 8'h00, "push");
    n_chk++; if (sp_out !== 8'hFF) $display("FAIL push sp got=%h exp=ff", sp_out); else n_pass++;
    n_chk++; if (ram[8'hFF] !== 10'h2A5) $display("FAIL push mem[ff] got=%h exp=2a5", ram[8'hFF]); else n_pass++;
    run_op(OP_POP, 10'h000, 2'b00, 8'h00, "pop");
    n_chk++; if (rdata !== 10'h2A5) $display("FAIL pop rdata got=%h exp=2a5", rdata); else n_pass++;
    run_op(OP_CALL, 10'h3C1, 2'b00, 8'h00, "call");
    run_op(OP_RET, 10'h000, 2'b00, 8'h00, "ret");
    run_op(OP_NOP, 10'h000, 2'b00, 8'h00, "nop");
  endtask

  task automatic test_int_reti();
    run_op(OP_INT, 10'h155, 2'b10, 8'h00, "int");
    n_chk++; if (ram[8'hFF] !== 10'h155) $display("FAIL int mem[ff] got=%h exp=155", ram[8'hFF]); else n_pass++;
    n_chk++; if (ram[8'hFE] !== 10'h002) $display("FAIL int mem[fe] got=%h exp=002", ram[8'hFE]); else n_pass++;
    n_chk++; if (sp_out !== 8'hFE) $display("FAIL int sp got=%h exp=fe", sp_out); else n_pass++;
    run_op(OP_RETI, 10'h000, 2'b00, 8'h00, "reti");
    n_chk++; if (rflags !== 2'b10) $display("FAIL reti rflags got=%b exp=10", rflags); else n_pass++;
    n_chk++; if (rdata !== 10'h155) $display("FAIL reti rdata got=%h exp=155", rdata); else n_pass++;
    n_chk++; if (sp_out !== 8'h00) $display("FAIL reti sp got=%h exp=00", sp_out); else n_pass++;
  endtask

  task automatic test_overflow();
    run_op(OP_LDSP, 10'h000, 2'b00, 8'h00, "ovf_ldsp0");
    for (int i = 0; i < 64; i++) run_op(OP_PUSH, 10'($urandom), 2'b00, 8'h00, "fill");
    n_chk++; if (sp_out !== 8'hC0) $display("FAIL full sp got=%h exp=c0", sp_out); else n_pass++;
    run_op(OP_PUSH, 10'h111, 2'b00, 8'h00, "push65");
    n_chk++; if (ovf !== 1'b1) $display("FAIL push65 ovf got=%b exp=1", ovf); else n_pass++;
    run_op(OP_LDSP, 10'h000, 2'b00, 8'h00, "ovf_clear");
    n_chk++; if (ovf !== 1'b0) $display("FAIL ldsp ovf got=%b exp=0", ovf); else n_pass++;
  endtask

  task automatic test_underflow();
    run_op(OP_POP, 10'h000, 2'b00, 8'h00, "pop_empty");
    n_chk++; if (unf !== 1'b1) $display("FAIL pop_empty unf got=%b exp=1", unf); else n_pass++;
    run_op(OP_PUSH, 10'h0AB, 2'b00, 8'h00, "push_one");
    run_op(OP_RETI, 10'h000, 2'b00, 8'h00, "reti_depth1");
    run_op(OP_LDSP, 10'h000, 2'b00, 8'h00, "unf_clear");
  endtask

  task automatic test_int_ovf();
    run_op(OP_LDSP, 10'h000, 2'b00, 8'hC1, "ldsp_d63");
    run_op(OP_INT, 10'h3FF, 2'b11, 8'h00, "int_d63");
    n_chk++; if (ovf !== 1'b1) $display("FAIL int_d63 ovf got=%b exp=1", ovf); else n_pass++;
    run_op(OP_LDSP, 10'h000, 2'b00, 8'hC2, "ldsp_d62");
    run_op(OP_INT, 10'h2C3, 2'b01, 8'h00, "int_d62");
    run_op(OP_LDSP, 10'h000, 2'b00, 8'h00, "ldsp_back");
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    op_valid = 1'b1; op = OP_INT; wd = 10'h1E7; fl = 2'b01;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_chk++; if (scr_we !== 1'b1) $display("FAIL rst_mid we in wr2 got=%b exp=1", scr_we); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_chk++; if (scr_we !== 1'b0) $display("FAIL rst_mid we after reset got=%b exp=0", scr_we); else n_pass++;
    n_chk++; if (sp_out !== 8'h00) $display("FAIL rst_mid sp got=%h exp=00", sp_out); else n_pass++;
    model_mem[8'hFF] = 10'h1E7;
    sp_m = 8'h00; ovf_m = 1'b0; unf_m = 1'b0; rd_m = '0; rf_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_state("rst_mid");
  endtask

  task automatic test_back_to_back();
    logic [5:0] pat;
    int dones;
    pat = '0; dones = 0;
    @(negedge clk);
    op_valid = 1'b1; op = OP_PUSH; wd = 10'h2D2;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      pat[c-1] = done;
      if (done) dones++;
    end
    op_valid = 1'b0;
    for (int i = 1; i <= 3; i++) model_mem[8'(8'h00 - i)] = 10'h2D2;
    sp_m = 8'hFD;
    n_chk++; if (pat !== 6'b010101) $display("FAIL b2b_push done pattern got=%b exp=010101", pat); else n_pass++;
    n_chk++; if (dones != 3) $display("FAIL b2b_push done count got=%0d exp=3", dones); else n_pass++;
    @(negedge clk);
    check_state("b2b_push");
    pat = '0; dones = 0;
    op_valid = 1'b1; op = OP_POP;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      pat[c-1] = done;
      if (done) dones++;
    end
    op_valid = 1'b0;
    sp_m = 8'hFF; rd_m = 10'h2D2;
    n_chk++; if (pat !== 6'b010010) $display("FAIL b2b_pop done pattern got=%b exp=010010", pat); else n_pass++;
    n_chk++; if (dones != 2) $display("FAIL b2b_pop done count got=%0d exp=2", dones); else n_pass++;
    @(negedge clk);
    check_state("b2b_pop");
  endtask

  task automatic test_random();
    logic [7:0] ldv [7];
    int r;
    ldv[0] = 8'h00; ldv[1] = 8'hC0; ldv[2] = 8'hC1; ldv[3] = 8'hC2;
    ldv[4] = 8'h01; ldv[5] = 8'h02; ldv[6] = 8'hF0;
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 11);
      case (r)
        0, 1, 2: run_op(OP_PUSH, 10'($urandom), 2'b00, 8'h00, "rnd_push");
        3:       run_op(OP_CALL, 10'($urandom), 2'b00, 8'h00, "rnd_call");
        4, 5:    run_op(OP_POP, 10'h000, 2'b00, 8'h00, "rnd_pop");
        6:       run_op(OP_RET, 10'h000, 2'b00, 8'h00, "rnd_ret");
        7:       run_op(OP_INT, 10'($urandom), 2'($urandom), 8'h00, "rnd_int");
        8:       run_op(OP_RETI, 10'h000, 2'b00, 8'h00, "rnd_reti");
        9:       run_op(OP_LDSP, 10'h000, 2'b00, ldv[$urandom_range(0, 6)], "rnd_ldsp");
        default: run_op(OP_NOP, 10'($urandom), 2'b00, 8'h00, "rnd_nop");
      endcase
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    op_valid = 1'b0; op = 3'd0; wd = '0; fl = '0; ld = '0; load_ram = 1'b1;
    for (int i = 0; i < 256; i++) model_mem[i] = 10'($urandom);
    test_reset();
    test_push_pop();
    test_int_reti();
    test_overflow();
    test_underflow();
    test_int_ovf();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
